// File: rtl/vec_writeback.sv
// ============================================================================
// vec_writeback
// ----------------------------------------------------------------------------
// Result writeback stage placed after the vector arithmetic stage. It takes
// 128-bit result beats over a valid/ready handshake. For each beat it works
// out the destination register and the byte enables from the instruction
// context that was latched at start. The writes are buffered and then
// retired to the register file write port under an ack handshake.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   start                 begin instruction (IDLE only); latches vd, vl,
//                         vsew, widening, reduction
//   vd[4:0]               first destination register
//   vl[5:0]               element count, 0..32
//   vsew[1:0]             source element width (0=8b, 1=16b, 2=32b)
//   widening              result elements are twice SEW
//   reduction             scalar result into element 0 of vd
//   res_valid/res_ready   result beat handshake
//   res_data[127:0]       result beat
//   res_last              final beat marker (reduction mode only)
//   vr_wr_en/vr_wr_ack    register file write handshake
//   vr_wr_addr[4:0]       register index
//   vr_wr_data[127:0]     write data
//   vr_wr_be[15:0]        byte enables, bit i covers byte i
//   busy                  instruction in flight
//   done                  one-cycle completion pulse
//   err                   one-cycle pulse after an illegal start
//
// Configuration macro: VEC_WB_SKID_EN
//   defined   : two-entry write buffer, full throughput under back-pressure
//   undefined : single holding register, accepts a new beat only when the
//               buffer is empty or is being retired in the same cycle
// ============================================================================
module vec_writeback (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [4:0]   vd,
   input  logic [5:0]   vl,
   input  logic [1:0]   vsew,
   input  logic         widening,
   input  logic         reduction,
   input  logic         res_valid,
   output logic         res_ready,
   input  logic [127:0] res_data,
   input  logic         res_last,
   output logic         vr_wr_en,
   output logic [4:0]   vr_wr_addr,
   output logic [127:0] vr_wr_data,
   output logic [15:0]  vr_wr_be,
   input  logic         vr_wr_ack,
   output logic         busy,
   output logic         done,
   output logic         err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Low n bits set, n in 0..16.
   function automatic logic [15:0] byte_mask(input logic [4:0] nbytes);
      logic [15:0] m;
      m = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         m[i] = (5'(i) < nbytes) ? 1'b1 : 1'b0;
      end
      return m;
   endfunction

   // FSM and latched instruction context
   state_t       state_r;
   logic [4:0]   vd_r;
   logic [1:0]   ew_r;
   logic         red_r;
   logic [5:0]   rem_r;
   logic [4:0]   beat_r;
   logic         busy_r;
   logic         done_r;
   logic         err_r;

   // Write buffer; the head entry drives the write port directly
   logic [1:0]   count_r;
   logic [4:0]   head_addr_r;
   logic [127:0] head_data_r;
   logic [15:0]  head_be_r;
`ifdef VEC_WB_SKID_EN
   logic [4:0]   tail_addr_r;
   logic [127:0] tail_data_r;
   logic [15:0]  tail_be_r;
`endif

   // Combinational helpers
   logic [2:0]   ew_in_s;
   logic         start_legal_s;
   logic [4:0]   epb_s;
   logic [4:0]   n_s;
   logic [4:0]   nbytes_s;
   logic         accept_s;
   logic         push_s;
   logic         pop_s;
   logic         final_s;
   logic         drain_empty_s;
   logic [4:0]   new_addr_s;
   logic [15:0]  new_be_s;

   assign vr_wr_en   = (count_r != 2'd0);
   assign vr_wr_addr = head_addr_r;
   assign vr_wr_data = head_data_r;
   assign vr_wr_be   = head_be_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign err        = err_r;

`ifdef VEC_WB_SKID_EN
   assign res_ready = (state_r == RUN) && (count_r != 2'd2);
`else
   // A new beat may only enter when the holding register frees up this cycle.
   assign res_ready = (state_r == RUN) && ((count_r == 2'd0) || (vr_wr_en && vr_wr_ack));
`endif

   // Start legality, per-beat element count and the buffer entry to push
   always_comb begin
      ew_in_s       = {1'b0, vsew} + {2'b00, widening};
      start_legal_s = (vsew != 2'd3) && (ew_in_s <= 3'd2);
      epb_s         = 5'd16 >> ew_r;
      // The remainder is below the per-beat capacity only on the last beat.
      if (rem_r < {1'b0, epb_s}) begin
         n_s = rem_r[4:0];
      end else begin
         n_s = epb_s;
      end
      nbytes_s      = n_s << ew_r;
      accept_s      = res_valid && res_ready;
      pop_s         = vr_wr_en && vr_wr_ack;
      drain_empty_s = (count_r == 2'd0) || ((count_r == 2'd1) && pop_s);
      if (red_r) begin
         // Only the res_last beat writes; it carries one element.
         push_s     = accept_s && res_last;
         final_s    = res_last;
         new_addr_s = vd_r;
         new_be_s   = byte_mask(5'd1 << ew_r);
      end else begin
         push_s     = accept_s;
         final_s    = (rem_r == {1'b0, n_s});
         new_addr_s = vd_r + beat_r;
         new_be_s   = byte_mask(nbytes_s);
      end
   end

   // Instruction FSM with registered busy/done/err
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         vd_r    <= 5'd0;
         ew_r    <= 2'd0;
         red_r   <= 1'b0;
         rem_r   <= 6'd0;
         beat_r  <= 5'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  if (start_legal_s) begin
                     vd_r    <= vd;
                     ew_r    <= ew_in_s[1:0];
                     red_r   <= reduction;
                     rem_r   <= vl;
                     beat_r  <= 5'd0;
                     busy_r  <= 1'b1;
                     // Nothing to write for vl=0: go straight to DRAIN.
                     state_r <= (vl == 6'd0) ? DRAIN : RUN;
                  end else begin
                     err_r <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (accept_s) begin
                  if (!red_r) begin
                     rem_r  <= rem_r - {1'b0, n_s};
                     beat_r <= beat_r + 5'd1;
                  end
                  if (final_s) begin
                     state_r <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Leave as the last buffered write retires so done lands on M+1.
               if (drain_empty_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Write buffer: head register plus optional tail entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r     <= 2'd0;
         head_addr_r <= 5'd0;
         head_data_r <= 128'd0;
         head_be_r   <= 16'd0;
`ifdef VEC_WB_SKID_EN
         tail_addr_r <= 5'd0;
         tail_data_r <= 128'd0;
         tail_be_r   <= 16'd0;
`endif
      end else begin
         count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
         if (push_s && ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s))) begin
            head_addr_r <= new_addr_s;
            head_data_r <= res_data;
            head_be_r   <= new_be_s;
         end
`ifdef VEC_WB_SKID_EN
         // Tail advances into the head when the head retires with two held.
         if (pop_s && (count_r == 2'd2)) begin
            head_addr_r <= tail_addr_r;
            head_data_r <= tail_data_r;
            head_be_r   <= tail_be_r;
         end
         if (push_s && (((count_r == 2'd1) && !pop_s) || ((count_r == 2'd2) && pop_s))) begin
            tail_addr_r <= new_addr_s;
            tail_data_r <= res_data;
            tail_be_r   <= new_be_s;
         end
`endif
      end
   end

endmodule
